// File: rtl/sniffer_pkg.sv
// Shared types and helpers for the sniffer packet-flow controller.
package sniffer_pkg;

  typedef enum logic [2:0] {
    CFG    = 3'd0,
    IDLE   = 3'd1,
    FILL   = 3'd2,
    DRAIN  = 3'd3,
    SETTLE = 3'd4,
    DECIDE = 3'd5,
    STORE  = 3'd6,
    ERR    = 3'd7
  } state_t;

  localparam int unsigned DEFAULT_CMP_LATENCY = 4;

  // Width of a counter able to hold values 0..lat.
  function automatic int unsigned settle_cnt_w(input int unsigned lat);
    return $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/sniffer_settle_timer.sv
// Loadable down-counter; o_done is high whenever the count is zero.
module sniffer_settle_timer
  import sniffer_pkg::*;
#(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_done
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/sniffer_flow_ctrl.sv
// Packet-flow controller: config load, FIFO fill/drain, comparator settle and match decision.
// Optional statistics counters enabled by defining SNIFFER_FLOW_STATS_EN.
module sniffer_flow_ctrl
  import sniffer_pkg::*;
#(
  parameter int unsigned NUM_RULES   = 4,
  parameter int unsigned CMP_LATENCY = DEFAULT_CMP_LATENCY,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned MAX_SLOTS   = 256
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 update_done,
  input  logic                 ready,
  input  logic                 eop,
  input  logic                 error,
  input  logic                 rdempty,
  input  logic [NUM_RULES-1:0] match,
  input  logic [NUM_RULES-1:0] rule_en,
  output logic                 rdreq,
  output logic                 cfg_sel,
  output logic                 clear,
  output logic                 inc_addr,
  output logic [ADDR_W-1:0]    wr_slot,
  output logic [NUM_RULES-1:0] hit_rules,
  output logic                 busy
`ifdef SNIFFER_FLOW_STATS_EN
  ,
  output logic [31:0]          pkt_cnt,
  output logic [31:0]          hit_cnt,
  output logic [31:0]          err_cnt
`endif
);

  localparam int unsigned          CNT_W    = settle_cnt_w(CMP_LATENCY);
  localparam logic [CNT_W-1:0]     LOAD_VAL = CNT_W'(CMP_LATENCY - 1);
  localparam logic [ADDR_W-1:0]    SLOT_MAX = ADDR_W'(MAX_SLOTS - 1);

  state_t                r_state;
  state_t                w_next;
  logic [NUM_RULES-1:0]  w_hits;
  logic                  w_settle_load;
  logic                  w_settle_dec;
  logic                  w_settle_done;

  logic                  r_rdreq;
  logic                  r_cfg_sel;
  logic                  r_clear;
  logic                  r_inc_addr;
  logic                  r_busy;
  logic [ADDR_W-1:0]     r_wr_slot;
  logic [NUM_RULES-1:0]  r_hit_rules;

  sniffer_settle_timer #(
    .CNT_W(CNT_W)
  ) u_settle (
    .clk        (clk),
    .n_rst      (n_rst),
    .i_load     (w_settle_load),
    .i_load_val (LOAD_VAL),
    .i_dec      (w_settle_dec),
    .o_done     (w_settle_done)
  );

  // Load on SETTLE entry so the count runs CMP_LATENCY-1 .. 0 while in SETTLE.
  assign w_settle_load = (w_next == SETTLE) && (r_state != SETTLE);
  assign w_settle_dec  = (r_state == SETTLE);
  assign w_hits        = match & rule_en;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= CFG;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      CFG:     if (update_done) w_next = IDLE;
      IDLE:    if (ready) w_next = FILL;
      FILL: begin
        if (eop)        w_next = DRAIN;
        else if (error) w_next = ERR;
      end
      DRAIN:   if (rdempty) w_next = SETTLE;
      SETTLE:  if (w_settle_done) w_next = DECIDE;
      DECIDE:  w_next = (w_hits != '0) ? STORE : IDLE;
      STORE:   w_next = IDLE;
      ERR:     if (eop) w_next = IDLE;
      default: w_next = CFG;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_rdreq     <= 1'b0;
      r_cfg_sel   <= 1'b0;
      r_clear     <= 1'b0;
      r_inc_addr  <= 1'b0;
      r_busy      <= 1'b0;
      r_wr_slot   <= '0;
      r_hit_rules <= '0;
    end else begin
      r_rdreq    <= (w_next == FILL);
      r_cfg_sel  <= (w_next == CFG);
      r_clear    <= (w_next == IDLE);
      r_inc_addr <= (w_next == STORE);
      r_busy     <= (w_next != IDLE);
      if (w_next == STORE) begin
        r_wr_slot <= (r_wr_slot == SLOT_MAX) ? '0 : r_wr_slot + 1'b1;
      end
      if (r_state == DECIDE) begin
        r_hit_rules <= w_hits;
      end
    end
  end

  assign rdreq     = r_rdreq;
  assign cfg_sel   = r_cfg_sel;
  assign clear     = r_clear;
  assign inc_addr  = r_inc_addr;
  assign busy      = r_busy;
  assign wr_slot   = r_wr_slot;
  assign hit_rules = r_hit_rules;

`ifdef SNIFFER_FLOW_STATS_EN
  logic [31:0] r_pkt_cnt;
  logic [31:0] r_hit_cnt;
  logic [31:0] r_err_cnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_pkt_cnt <= '0;
      r_hit_cnt <= '0;
      r_err_cnt <= '0;
    end else begin
      if ((w_next == DRAIN) && (r_state != DRAIN) && (r_pkt_cnt != '1)) begin
        r_pkt_cnt <= r_pkt_cnt + 1'b1;
      end
      if ((w_next == STORE) && (r_state != STORE) && (r_hit_cnt != '1)) begin
        r_hit_cnt <= r_hit_cnt + 1'b1;
      end
      if ((w_next == ERR) && (r_state != ERR) && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  assign pkt_cnt = r_pkt_cnt;
  assign hit_cnt = r_hit_cnt;
  assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_sniffer_flow_ctrl.sv
// Directed, table-driven bench for sniffer_flow_ctrl plus hand sequences for wrap, reset and CMP_LATENCY=1.
module tb_sniffer_flow_ctrl;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       update_done = 1'b0, ready = 1'b0, eop = 1'b0, error = 1'b0, rdempty = 1'b0;
  logic [3:0] match = 4'hF, rule_en = 4'hF;
  logic       rdreq, cfg_sel, clear, inc_addr, busy;
  logic [7:0] wr_slot;
  logic [3:0] hit_rules;

  // Second instance: CMP_LATENCY=1, 3 slots.
  logic       b_ud = 1'b0, b_ready = 1'b0, b_eop = 1'b0, b_err = 1'b0, b_empty = 1'b0;
  logic [3:0] b_match = 4'h0, b_ren = 4'h0;
  logic       b_rdreq, b_cfg, b_clear, b_inc, b_busy;
  logic [1:0] b_slot;
  logic [3:0] b_hit;

`ifdef SNIFFER_FLOW_STATS_EN
  logic [31:0] pkt_cnt, hit_cnt, err_cnt;
  logic [31:0] b_pkt, b_hitc, b_errc;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sniffer_flow_ctrl #(
    .NUM_RULES(4), .CMP_LATENCY(4), .ADDR_W(8), .MAX_SLOTS(256)
  ) u_dut (
    .clk(clk), .n_rst(n_rst), .update_done(update_done), .ready(ready), .eop(eop),
    .error(error), .rdempty(rdempty), .match(match), .rule_en(rule_en),
    .rdreq(rdreq), .cfg_sel(cfg_sel), .clear(clear), .inc_addr(inc_addr),
    .wr_slot(wr_slot), .hit_rules(hit_rules), .busy(busy)
`ifdef SNIFFER_FLOW_STATS_EN
    , .pkt_cnt(pkt_cnt), .hit_cnt(hit_cnt), .err_cnt(err_cnt)
`endif
  );

  sniffer_flow_ctrl #(
    .NUM_RULES(4), .CMP_LATENCY(1), .ADDR_W(2), .MAX_SLOTS(3)
  ) u_dut1 (
    .clk(clk), .n_rst(n_rst), .update_done(b_ud), .ready(b_ready), .eop(b_eop),
    .error(b_err), .rdempty(b_empty), .match(b_match), .rule_en(b_ren),
    .rdreq(b_rdreq), .cfg_sel(b_cfg), .clear(b_clear), .inc_addr(b_inc),
    .wr_slot(b_slot), .hit_rules(b_hit), .busy(b_busy)
`ifdef SNIFFER_FLOW_STATS_EN
    , .pkt_cnt(b_pkt), .hit_cnt(b_hitc), .err_cnt(b_errc)
`endif
  );

  typedef struct packed {
    logic [4:0] ic;   // {update_done, ready, eop, error, rdempty}
    logic [3:0] m;
    logic [3:0] r;
    logic [4:0] oc;   // {rdreq, cfg_sel, clear, inc_addr, busy}
    logic [7:0] s;
    logic [3:0] h;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic [4:0] ic, input logic [3:0] m, input logic [3:0] r,
                              input logic [4:0] oc, input logic [7:0] s, input logic [3:0] h);
    vec_t v;
    v.ic = ic; v.m = m; v.r = r; v.oc = oc; v.s = s; v.h = h;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One matching packet from IDLE; counts inc_addr cycles until busy drops.
  task automatic run_pkt(output int incs);
    incs = 0;
    match = 4'h1; rule_en = 4'h1;
    ready = 1'b1; tick();
    ready = 1'b0; eop = 1'b1; tick();
    eop = 1'b0; rdempty = 1'b1; tick();
    rdempty = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (inc_addr) incs++;
      if (!busy) break;
    end
  endtask

  initial begin
    int   incs;
    logic [7:0] exp_slot;
    logic [1:0] b_exp;

    // Table: inputs applied before an edge, outputs expected just after it.
    vq.push_back(mk(5'b00000, 4'hF, 4'hF, 5'b01001, 8'd0, 4'h0)); // CFG
    vq.push_back(mk(5'b00000, 4'hF, 4'hF, 5'b01001, 8'd0, 4'h0));
    vq.push_back(mk(5'b10000, 4'hF, 4'hF, 5'b00100, 8'd0, 4'h0)); // -> IDLE
    vq.push_back(mk(5'b00000, 4'hF, 4'hF, 5'b00100, 8'd0, 4'h0));
    vq.push_back(mk(5'b01000, 4'hF, 4'hF, 5'b10001, 8'd0, 4'h0)); // -> FILL
    vq.push_back(mk(5'b00000, 4'hF, 4'hF, 5'b10001, 8'd0, 4'h0));
    vq.push_back(mk(5'b00100, 4'hF, 4'hF, 5'b00001, 8'd0, 4'h0)); // -> DRAIN
    vq.push_back(mk(5'b00000, 4'hF, 4'hF, 5'b00001, 8'd0, 4'h0));
    vq.push_back(mk(5'b00001, 4'hF, 4'hF, 5'b00001, 8'd0, 4'h0)); // -> SETTLE
    vq.push_back(mk(5'b00000, 4'hF, 4'hF, 5'b00001, 8'd0, 4'h0));
    vq.push_back(mk(5'b01000, 4'hF, 4'hF, 5'b00001, 8'd0, 4'h0)); // ready ignored
    vq.push_back(mk(5'b00010, 4'hF, 4'hF, 5'b00001, 8'd0, 4'h0)); // error ignored
    vq.push_back(mk(5'b00000, 4'hF, 4'hF, 5'b00001, 8'd0, 4'h0)); // -> DECIDE
    vq.push_back(mk(5'b00000, 4'h4, 4'h6, 5'b00011, 8'd1, 4'h4)); // -> STORE
    vq.push_back(mk(5'b00000, 4'hF, 4'hF, 5'b00100, 8'd1, 4'h4)); // -> IDLE
    vq.push_back(mk(5'b00000, 4'hF, 4'hF, 5'b00100, 8'd1, 4'h4));
    vq.push_back(mk(5'b01000, 4'hF, 4'hF, 5'b10001, 8'd1, 4'h4)); // -> FILL
    vq.push_back(mk(5'b00110, 4'hF, 4'hF, 5'b00001, 8'd1, 4'h4)); // eop beats error
    vq.push_back(mk(5'b00001, 4'hF, 4'hF, 5'b00001, 8'd1, 4'h4)); // -> SETTLE
    vq.push_back(mk(5'b00000, 4'hF, 4'hF, 5'b00001, 8'd1, 4'h4));
    vq.push_back(mk(5'b00000, 4'hF, 4'hF, 5'b00001, 8'd1, 4'h4));
    vq.push_back(mk(5'b00000, 4'hF, 4'hF, 5'b00001, 8'd1, 4'h4));
    vq.push_back(mk(5'b00000, 4'hF, 4'hF, 5'b00001, 8'd1, 4'h4)); // -> DECIDE
    vq.push_back(mk(5'b00000, 4'h9, 4'h6, 5'b00100, 8'd1, 4'h0)); // no hit -> IDLE
    vq.push_back(mk(5'b01000, 4'hF, 4'hF, 5'b10001, 8'd1, 4'h0)); // -> FILL
    vq.push_back(mk(5'b00010, 4'hF, 4'hF, 5'b00001, 8'd1, 4'h0)); // -> ERR
    vq.push_back(mk(5'b00010, 4'hF, 4'hF, 5'b00001, 8'd1, 4'h0));
    vq.push_back(mk(5'b00000, 4'hF, 4'hF, 5'b00001, 8'd1, 4'h0));
    vq.push_back(mk(5'b00001, 4'hF, 4'hF, 5'b00001, 8'd1, 4'h0));
    vq.push_back(mk(5'b00000, 4'hF, 4'hF, 5'b00001, 8'd1, 4'h0));
    vq.push_back(mk(5'b00100, 4'hF, 4'hF, 5'b00100, 8'd1, 4'h0)); // eop -> IDLE
    vq.push_back(mk(5'b10000, 4'hF, 4'hF, 5'b00100, 8'd1, 4'h0)); // update_done ignored

    #2;
    chk("reset_outputs", {15'd0, rdreq, cfg_sel, clear, inc_addr, busy, wr_slot, hit_rules}, 32'd0);
    #10 n_rst = 1'b1;
    #3;  // t=15 edge occurs next; first table edge follows from t=16
    @(posedge clk); #1;
    // One clock after release already elapsed: still CFG with cfg_sel high.
    chk("cfg_after_release", {30'd0, cfg_sel, busy}, 32'd3);

    foreach (vq[i]) begin
      {update_done, ready, eop, error, rdempty} = vq[i].ic;
      match = vq[i].m;
      rule_en = vq[i].r;
      tick();
      chk($sformatf("vec%0d", i),
          {15'd0, rdreq, cfg_sel, clear, inc_addr, busy, wr_slot, hit_rules},
          {15'd0, vq[i].oc, vq[i].s, vq[i].h});
    end
    {update_done, ready, eop, error, rdempty} = 5'b0;

`ifdef SNIFFER_FLOW_STATS_EN
    chk("stats_pkt", pkt_cnt, 32'd2);
    chk("stats_hit", hit_cnt, 32'd1);
    chk("stats_err", err_cnt, 32'd1);
`endif

    // Wrap: slot is 1 here; 255 more stores reach 255 then wrap to 0.
    exp_slot = 8'd1;
    for (int k = 0; k < 255; k++) begin
      run_pkt(incs);
      exp_slot = exp_slot + 8'd1;
      chk($sformatf("wrap_inc%0d", k), incs, 32'd1);
      chk($sformatf("wrap_slot%0d", k), {24'd0, wr_slot}, {24'd0, exp_slot});
      chk($sformatf("wrap_idle%0d", k), {31'd0, busy}, 32'd0);
    end
    chk("wrap_final", {24'd0, wr_slot}, 32'd0);
`ifdef SNIFFER_FLOW_STATS_EN
    chk("stats_pkt2", pkt_cnt, 32'd257);
    chk("stats_hit2", hit_cnt, 32'd256);
`endif

    // Reset asserted mid-SETTLE.
    match = 4'hF; rule_en = 4'hF;
    ready = 1'b1; tick();
    ready = 1'b0; eop = 1'b1; tick();
    eop = 1'b0; rdempty = 1'b1; tick();
    rdempty = 1'b0; tick();
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    #2 n_rst = 1'b0;
    #1;
    chk("midreset_outputs", {15'd0, rdreq, cfg_sel, clear, inc_addr, busy, wr_slot, hit_rules}, 32'd0);
`ifdef SNIFFER_FLOW_STATS_EN
    chk("midreset_stats", pkt_cnt | hit_cnt | err_cnt, 32'd0);
`endif
    @(negedge clk);
    n_rst = 1'b1;
    tick();
    chk("post_reset_cfg", {27'd0, rdreq, cfg_sel, clear, inc_addr, busy}, 32'b01001);
    tick();
    chk("post_reset_hold", {27'd0, rdreq, cfg_sel, clear, inc_addr, busy}, 32'b01001);

    // CMP_LATENCY=1 instance: one SETTLE cycle, 3-slot wrap.
    b_ud = 1'b1; tick();
    b_ud = 1'b0;
    chk("b_idle", {30'd0, b_clear, b_busy}, 32'b10);
    b_exp = 2'd0;
    for (int p = 0; p < 3; p++) begin
      b_match = 4'h8; b_ren = 4'hC;
      b_ready = 1'b1; tick();
      b_ready = 1'b0; b_eop = 1'b1; tick();
      b_eop = 1'b0; b_empty = 1'b1; tick();
      b_empty = 1'b0;
      tick();
      chk($sformatf("b_decide%0d", p), {30'd0, b_inc, b_busy}, 32'b01);
      tick();
      b_exp = (b_exp == 2'd2) ? 2'd0 : b_exp + 2'd1;
      chk($sformatf("b_store%0d", p), {26'd0, b_inc, b_slot, b_hit[3]}, {26'd0, 1'b1, b_exp, 1'b1});
      tick();
      chk($sformatf("b_back%0d", p), {30'd0, b_inc, b_clear}, 32'b01);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
